// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and forwarding controller for the 5-stage RV32I
// pipeline. It picks the ALU operand forwarding sources, stalls IF/ID on a
// load-use hazard, squashes wrong-path work on a registered EX redirect, and
// keeps saturating stall/flush event counters for bring-up.
//
// Build option: define EX_FWD_EN to enable operand forwarding. Without it,
// fwd_a/fwd_b stay at 00 and any used ID source that matches id_ex_rd or
// ex_mem_rd stalls ID until the producer reaches MEM/WB.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      IF/ID holds a real instruction
//   id_rs1/id_rs2, id_use_rs1/2   ID source registers and their read flags
//   ex_rs1/ex_rs2                 source registers held in ID/EX
//   id_ex_rd/_regwrite/_wb_sel    EX producer destination, write, load flag
//   ex_mem_rd/_regwrite           EX/MEM producer
//   mem_wb_rd/_regwrite           MEM/WB producer
//   pc_sel                        registered redirect from EX/MEM
//   stall_pc, stall_if_id         hold PC and IF/ID
//   flush_if_id, bubble_id_ex     clear IF/ID, insert a NOP into ID/EX
//   kill_ex                       drop the EX/MEM write enables at next edge
//   fwd_a, fwd_b                  00 regfile, 01 EX/MEM, 10 MEM/WB
//   state                         00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt          saturating event counters
//
// State  | meaning
// RUN    | normal issue
// STALL  | ID held behind a producer that cannot forward yet
// FLUSH  | one cycle after a redirect; IF/ID holds a squashed slot
module ex_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_regwrite,
  input  logic             id_ex_wb_sel,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwrite,
  input  logic             pc_sel,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             kill_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   hazard;
  logic   stall_det;

  // ID sources against the producer currently in EX
  logic ex_hit_rs1, ex_hit_rs2;
  assign ex_hit_rs1 = id_ex_regwrite && (id_ex_rd != 5'd0) && id_use_rs1 && (id_rs1 == id_ex_rd);
  assign ex_hit_rs2 = id_ex_regwrite && (id_ex_rd != 5'd0) && id_use_rs2 && (id_rs2 == id_ex_rd);

`ifdef EX_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is
  // covered by the EX/MEM and MEM/WB bypasses.
  assign hazard = id_valid && id_ex_wb_sel && (ex_hit_rs1 || ex_hit_rs2);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    // EX/MEM holds the younger value, so it is tested first
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rs1))
      fwd_a = 2'b01;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rs1))
      fwd_a = 2'b10;
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rs2))
      fwd_b = 2'b01;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rs2))
      fwd_b = 2'b10;
  end
`else
  // No bypass: wait until the producer has left EX/MEM. MEM/WB is safe
  // because the register file writes through.
  logic mem_hit_rs1, mem_hit_rs2;
  assign mem_hit_rs1 = ex_mem_regwrite && (ex_mem_rd != 5'd0) && id_use_rs1 && (id_rs1 == ex_mem_rd);
  assign mem_hit_rs2 = ex_mem_regwrite && (ex_mem_rd != 5'd0) && id_use_rs2 && (id_rs2 == ex_mem_rd);
  assign hazard = id_valid && (ex_hit_rs1 || ex_hit_rs2 || mem_hit_rs1 || mem_hit_rs2);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{id_ex_wb_sel, ex_rs1, ex_rs2, mem_wb_rd, mem_wb_regwrite};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall_det    = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    kill_ex      = 1'b0;

    // In FLUSH the ID slot is a squashed instruction, so its hazards are moot
    stall_det = hazard && (state_q != FLUSH);

    if (pc_sel) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      kill_ex      = 1'b1;
    end else if (stall_det) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end

    case (state_q)
      RUN, STALL: begin
        if (pc_sel)         state_d = FLUSH;
        else if (stall_det) state_d = STALL;
        else                state_d = RUN;
      end
      FLUSH: begin
        if (pc_sel) state_d = FLUSH;
        else        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (pc_sel && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  localparam int CNT_W = 4;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // {stall_pc, stall_if_id, flush_if_id, bubble_id_ex, kill_ex, fwd_a, fwd_b}
  localparam logic [8:0] H_IDLE  = 9'b0_0_0_0_0_00_00;
  localparam logic [8:0] H_STALL = 9'b1_1_0_1_0_00_00;
  localparam logic [8:0] H_REDIR = 9'b0_0_1_1_1_00_00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       id_ex_regwrite, id_ex_wb_sel, ex_mem_regwrite, mem_wb_regwrite, pc_sel;

  logic             stall_pc, stall_if_id, flush_if_id, bubble_id_ex, kill_ex;
  logic [1:0]       fwd_a, fwd_b, state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_wb_sel(id_ex_wb_sel),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .pc_sel(pc_sel),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .kill_ex(kill_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  logic [8:0] haz_obs;
  assign haz_obs = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex, kill_ex, fwd_a, fwd_b};

  typedef struct {
    string      tag;
    logic [8:0] haz;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] m_sc = 4'd0;
  logic [3:0] m_fc = 4'd0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0; id_ex_wb_sel = 1'b0;
    ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b0;
    pc_sel = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic lu_inputs();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_ex_rd = 5'd5; id_ex_regwrite = 1'b1; id_ex_wb_sel = 1'b1;
  endtask

  // Called at a negedge with inputs already driven: queue the expectation,
  // check it just after, advance the counter model, then move to next negedge.
  task automatic cyc(input string tag, input logic [8:0] haz, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.haz = haz; e.st = st; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".haz"},   16'(haz_obs),   16'(e.haz));
    check_eq({e.tag, ".state"}, 16'(state),     16'(e.st));
    check_eq({e.tag, ".scnt"},  16'(stall_cnt), 16'(e.sc));
    check_eq({e.tag, ".fcnt"},  16'(flush_cnt), 16'(e.fc));
    if (!rst) begin
      if (haz[8] && m_sc != 4'hf) m_sc = m_sc + 4'd1;
      if (pc_sel && m_fc != 4'hf) m_fc = m_fc + 4'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    cyc("reset", H_IDLE, S_RUN);
    rst = 1'b0;

    // load-use
    idle(); lu_inputs();
    cyc("lu_detect", H_STALL, S_RUN);
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0; id_ex_wb_sel = 1'b0;
    ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
    cyc("lu_stall", FWD ? H_IDLE : H_STALL, S_STALL);
`ifdef EX_FWD_EN
    idle(); id_valid = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
    mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
    cyc("lu_fwd", 9'b0_0_0_0_0_10_00, S_RUN);
`else
    idle(); id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
    cyc("lu_wt", H_IDLE, S_STALL);
    idle(); ex_rs1 = 5'd5; ex_rs2 = 5'd1;
    cyc("lu_ex", H_IDLE, S_RUN);
`endif

    // add x3 ; sub x4,x3,x3
    idle(); id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd3;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_ex_rd = 5'd3; id_ex_regwrite = 1'b1;
    cyc("alu_id", FWD ? H_IDLE : H_STALL, S_RUN);
`ifdef EX_FWD_EN
    idle(); ex_rs1 = 5'd3; ex_rs2 = 5'd3; ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    cyc("alu_exmem", 9'b0_0_0_0_0_01_01, S_RUN);
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    cyc("alu_prio", 9'b0_0_0_0_0_01_01, S_RUN);
    ex_mem_regwrite = 1'b0;
    cyc("alu_memwb", 9'b0_0_0_0_0_10_10, S_RUN);
    ex_rs2 = 5'd7;
    cyc("alu_mix", 9'b0_0_0_0_0_10_00, S_RUN);
`else
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    cyc("raw_exmem", H_STALL, S_STALL);
    ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    cyc("raw_wt", H_IDLE, S_STALL);
    idle(); ex_rs1 = 5'd3; ex_rs2 = 5'd3; ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    cyc("raw_nofwd", H_IDLE, S_RUN);
`endif

    // redirect beats a concurrent load-use
    idle(); lu_inputs(); pc_sel = 1'b1;
    cyc("redir", H_REDIR, S_RUN);
    pc_sel = 1'b0;
    cyc("flush_sup", H_IDLE, S_FLUSH);
    idle();
    cyc("flush_end", H_IDLE, S_RUN);

    // stall held, then redirect out of STALL
    idle(); lu_inputs();
    cyc("hold1", H_STALL, S_RUN);
    cyc("hold2", H_STALL, S_STALL);
    pc_sel = 1'b1;
    cyc("stall_redir", H_REDIR, S_STALL);
    idle();
    cyc("after_redir", H_IDLE, S_FLUSH);
    cyc("back_run", H_IDLE, S_RUN);

    // x0, idle, unused-source and no-write cases
    idle(); lu_inputs(); id_rs1 = 5'd0; id_ex_rd = 5'd0;
    cyc("x0_load", H_IDLE, S_RUN);
    idle(); lu_inputs(); id_valid = 1'b0;
    cyc("no_valid", H_IDLE, S_RUN);
    idle(); lu_inputs(); id_use_rs1 = 1'b0;
    cyc("no_use", H_IDLE, S_RUN);
    idle(); lu_inputs(); id_ex_regwrite = 1'b0;
    cyc("no_rw", H_IDLE, S_RUN);
    idle(); ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b1;
    cyc("x0_fwd", H_IDLE, S_RUN);
    idle(); lu_inputs(); id_rs1 = 5'd9; id_rs2 = 5'd5;
    cyc("lu_rs2", H_STALL, S_RUN);
    idle();
    cyc("lu_rs2_st", H_IDLE, S_STALL);
    cyc("lu_rs2_run", H_IDLE, S_RUN);

    // reset in the middle of a stall
    idle(); lu_inputs();
    cyc("pre_rst", H_STALL, S_RUN);
    check_eq("mid_stall_state", 16'(state), 16'(S_STALL));
    #2 rst = 1'b1;
    #1;
    check_eq("rst_stall_state", 16'(state), 16'(S_RUN));
    check_eq("rst_stall_scnt", 16'(stall_cnt), 16'd0);
    m_sc = 4'd0; m_fc = 4'd0;
    @(negedge clk);
    rst = 1'b0; idle();
    cyc("post_rst", H_IDLE, S_RUN);

    // flush counter saturation with pc_sel held high
    idle(); pc_sel = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("sat", H_REDIR, (i == 0) ? S_RUN : S_FLUSH);
    check_eq("sat_fcnt", 16'(flush_cnt), 16'd15);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_sat_state", 16'(state), 16'(S_RUN));
    check_eq("rst_sat_fcnt", 16'(flush_cnt), 16'd0);
    check_eq("rst_sat_scnt", 16'(stall_cnt), 16'd0);
    m_sc = 4'd0; m_fc = 4'd0;
    @(negedge clk);
    rst = 1'b0; idle();
    cyc("final", H_IDLE, S_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and forwarding controller for the 5-stage RV32I pipeline. It sits beside the ID/EX and EX/MEM pipeline registers and sequences the execute datapath:
- selects ALU operand forwarding sources;
- stalls IF/ID on load-use (or on any RAW hazard when forwarding is compiled out);
- squashes wrong-path instructions when the registered EX redirect (`pc_sel`) fires;
- keeps saturating stall and flush counters for bring-up.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and flush counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: IF/ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction reads that source.
- `ex_rs1`, `ex_rs2` in 5 each: source registers held in ID/EX.
- `id_ex_rd` in 5, `id_ex_regwrite` in 1, `id_ex_wb_sel` in 1: destination, write enable and load flag of the instruction in EX.
- `ex_mem_rd` in 5, `ex_mem_regwrite` in 1: EX/MEM destination and write enable.
- `mem_wb_rd` in 5, `mem_wb_regwrite` in 1: MEM/WB destination and write enable.
- `pc_sel` in 1: registered redirect (branch taken or jump) from the EX/MEM register.
- `stall_pc` out 1: hold the PC.
- `stall_if_id` out 1: hold IF/ID.
- `flush_if_id` out 1: clear IF/ID to a bubble.
- `bubble_id_ex` out 1: load a NOP into ID/EX (all enables 0).
- `kill_ex` out 1: zero the memwrite and regwrite enables captured into EX/MEM at the next edge.
- `fwd_a`, `fwd_b` out 2 each: operand source. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback.
- `state` out 2: 00 RUN, 01 STALL, 10 FLUSH.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters.

## Operation
Hazard terms. A match requires the producer's regwrite = 1, its rd ≠ 0, and the matching `id_use_*` = 1 (ID side).
- **Load-use:** `id_valid`, `id_ex_wb_sel` = 1, and `id_ex_rd` equals a used ID source.
- **Forwarding:** for each EX operand, an EX/MEM match gives 01. Otherwise a MEM/WB match gives 10. Otherwise 00. EX/MEM has priority over MEM/WB.
- **Stall:** asserts `stall_pc`, `stall_if_id` and `bubble_id_ex` together.
- **Redirect** (`pc_sel` = 1): asserts `flush_if_id`, `bubble_id_ex` and `kill_ex`, and forces `stall_pc`/`stall_if_id` to 0. Redirect beats stall in the same cycle.

FSM (registered; hazard outputs are combinational from inputs and state):
- RUN: redirect → FLUSH; stall → STALL; otherwise stay in RUN.
- STALL: redirect → FLUSH; stall still true → STALL; otherwise → RUN.
- FLUSH: lasts exactly 1 cycle. Stall detection is suppressed, because IF/ID holds the squashed slot.
  - `pc_sel` = 1 again → FLUSH.
  - Otherwise → RUN.

Counters:
- `stall_cnt` increments each cycle `stall_pc` = 1.
- `flush_cnt` increments each cycle `pc_sel` = 1.
- Both saturate at all-ones and never wrap.

## Timing
- Hazard outputs: 0-cycle (same-cycle) response to inputs.
- `state` and the counters update on `posedge clk`.
- A load-use stall is exactly 1 cycle. The consumer then receives the load data via `fwd` = 10.
- Register file is write-through, so a MEM/WB producer never stalls the ID stage.
- Reset values (while `rst` is high, asynchronous):
  - `state` = RUN.
  - Both counters = 0.
  - All hazard outputs = 0 and both `fwd` = 00, provided the inputs are idle.
- Reset mid-stall: the FSM returns to RUN at once, and the counters clear.
- `id_valid` = 0 never produces a stall.

## Configuration
Macro `EX_FWD_EN`:
- **Defined:** forwarding is active as described above.
- **Undefined:**
  - `fwd_a` and `fwd_b` are tied to 00.
  - A stall is raised for any used ID source matching `id_ex_rd` or `ex_mem_rd` (with regwrite = 1 and rd ≠ 0).
  - A dependent instruction stalls up to 2 cycles, with the FSM remaining in STALL.
  - The redirect, FLUSH and counter behaviour is unchanged.

## Test plan
- **Load-use:** `lw x5` in EX, `add x6,x5,x1` in ID → stall 1 cycle, `state` RUN→STALL→RUN, then `fwd_a` = 10 in the `add`'s EX cycle, `stall_cnt` = 1.
- **Back-to-back ALU:** `add x3` then `sub x4,x3,x3` → no stall, `fwd_a` = `fwd_b` = 01. When x3 is also in MEM/WB, EX/MEM still wins.
- **Redirect over stall:** `pc_sel` = 1 while a load-use is detected → `flush_if_id` = `bubble_id_ex` = `kill_ex` = 1, `stall_pc` = 0, next state FLUSH for 1 cycle, `flush_cnt` = 1.
- **x0 and idle cases:** producer rd = 0 or `id_valid` = 0 → no stall and `fwd` = 00.
- **`EX_FWD_EN` undefined:** `add x3` followed immediately by a dependent instruction → 2 stall cycles, `fwd` held at 00.
- **Saturation:** `CNT_W` = 4, `pc_sel` held high 20 cycles → `flush_cnt` = 15, `state` remains FLUSH. Asserting `rst` mid-sequence → counters 0 and `state` RUN immediately.
